ks_multiword_add_sequencer: RTL

//  Multi-precision add/subtract controller around one parallel_prefix_adder_Kogge_Stone_adder
//  (BITS wide). It accepts WORDS*BITS-bit operands in one handshake and walks them through the

---
 rtl/ks_multiword_add_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ks_multiword_add_sequencer.sv
// rtl/ks_multiword_add_sequencer.sv - multi-word add/sub sequencer around a shared Kogge-Stone adder (optional KS_SEQ_SUB_EN)

module parallel_prefix_adder_Kogge_Stone_adder #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            ci,
  output logic [BITS-1:0] sum,
  output logic            co
);

  logic [BITS-1:0] g;
  logic [BITS-1:0] p;
  logic [BITS-1:0] gn;
  logic [BITS-1:0] pn;
  logic [BITS:0]   c;

  // Prefix tree: after the last level g[i]/p[i] cover bits i..0, so ci folds in at the end
  always_comb begin
    gn = '0;
    pn = '0;
    g  = a & b;
    p  = a ^ b;
    for (int d = 1; d < BITS; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < BITS; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    c[0] = ci;
    for (int i = 0; i < BITS; i++) begin
      c[i+1] = g[i] | (p[i] & ci);
    end
  end

  assign sum = a ^ b ^ c[BITS-1:0];
  assign co  = c[BITS];

endmodule

module ks_multiword_add_sequencer #(
  parameter int BITS  = 8,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [BITS*WORDS-1:0] a,
  input  logic [BITS*WORDS-1:0] b,
  input  logic                  ci,
`ifdef KS_SEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [BITS*WORDS-1:0] s,
  output logic                  co,
  output logic                  busy
);

  localparam int W  = BITS * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    s_reg;
  logic            co_reg;
  logic            carry;
  logic [IW-1:0]   idx;
  logic            sub_reg;
  logic            accept;
  logic [BITS-1:0] add_a;
  logic [BITS-1:0] add_b;
  logic [BITS-1:0] add_sum;
  logic            add_co;

  assign accept = start_valid && start_ready;

  // Current word feeds the shared adder; subtraction inverts B here so b_reg holds the raw operand
  assign add_a = a_reg[int'(idx)*BITS +: BITS];
  assign add_b = sub_reg ? ~b_reg[int'(idx)*BITS +: BITS] : b_reg[int'(idx)*BITS +: BITS];

  parallel_prefix_adder_Kogge_Stone_adder #(
    .BITS (BITS)
  ) u_adder (
    .a   (add_a),
    .b   (add_b),
    .ci  (carry),
    .sum (add_sum),
    .co  (add_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    case (state)
      ST_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (idx == LAST_IDX) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  // Operand capture on accept, then one word per clock with the carry chained between words
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      s_reg   <= '0;
      co_reg  <= 1'b0;
      carry   <= 1'b0;
      idx     <= '0;
      sub_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= '0;
`ifdef KS_SEQ_SUB_EN
            sub_reg <= sub;
            carry   <= sub ? 1'b1 : ci;
`else
            sub_reg <= 1'b0;
            carry   <= ci;
`endif
          end
        end
        ST_RUN: begin
          s_reg[int'(idx)*BITS +: BITS] <= add_sum;
          carry <= add_co;
          if (idx == LAST_IDX) begin
            co_reg <= add_co;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign s  = s_reg;
  assign co = co_reg;

endmodule
